// File: rtl/jam_cost_if.sv
// Bus between the permutation generator / cost table (master) and the
// cost tracker (slave).
interface jam_cost_if #(
   parameter int unsigned N   = 8,
   parameter int unsigned IW  = $clog2(N),
   parameter int unsigned CW  = 7,
   parameter int unsigned SW  = 10,
   parameter int unsigned MCW = 16,
   parameter int unsigned PW  = 16
) ();
   logic            start;
   logic            clear;
   logic [N*IW-1:0] arrange;
   logic [IW-1:0]   W;
   logic [IW-1:0]   J;
   logic [CW-1:0]   Cost;
   logic [SW-1:0]   MinCost;
   logic [MCW-1:0]  MatchCount;
   logic [PW-1:0]   BestIdx;
   logic            busy;
   logic            done;

   modport master (
      output start, clear, arrange, Cost,
      input  W, J, MinCost, MatchCount, BestIdx, busy, done
   );

   modport slave (
      input  start, clear, arrange, Cost,
      output W, J, MinCost, MatchCount, BestIdx, busy, done
   );
endinterface

// File: rtl/jam_cost_tracker.sv
// Sums the worker/job costs of one permutation per evaluation and tracks the
// minimum total, how many permutations hit it, and the first one that did.
module jam_cost_tracker #(
   parameter int unsigned N   = 8,
   parameter int unsigned IW  = $clog2(N),
   parameter int unsigned CW  = 7,
   parameter int unsigned SW  = 10,
   parameter int unsigned MCW = 16,
   parameter int unsigned PW  = 16
) (
   input logic         CLK,
   input logic         RST,
   jam_cost_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, ACC, CMP} state_t;

   localparam logic [IW-1:0] LAST = IW'(N - 1);

   state_t         state_q, state_d;
   logic [IW-1:0]  arr_q [N];
   logic [IW-1:0]  arr_d [N];
   logic [IW-1:0]  arr_in [N];
   logic [IW-1:0]  w_q, w_d;
   logic [IW-1:0]  j_q, j_d;
   logic [IW-1:0]  w_inc;
   logic [SW-1:0]  sum_q, sum_d;
   logic [SW-1:0]  min_q, min_d;
   logic [MCW-1:0] cnt_q, cnt_d;
   logic [PW-1:0]  perm_q, perm_d;
   logic [PW-1:0]  best_q, best_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   // Unpack the incoming permutation into one slot per worker.
   always_comb begin : unpack_arrange
      for (int k = 0; k < N; k++) begin
         arr_in[k] = bus.arrange[k*IW +: IW];
      end
   end

   assign w_inc = w_q + IW'(1);

   // The W register doubles as the worker counter k; J is prefetched one
   // cycle ahead so both lookup indices leave the block straight from flops.
   always_comb begin : next_state
      state_d = state_q;
      arr_d   = arr_q;
      w_d     = w_q;
      j_d     = j_q;
      sum_d   = sum_q;
      min_d   = min_q;
      cnt_d   = cnt_q;
      perm_d  = perm_q;
      best_d  = best_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.clear) begin
               min_d  = '1;
               cnt_d  = '0;
               perm_d = '0;
               best_d = '0;
            end
            if (bus.start) begin
               arr_d   = arr_in;
               sum_d   = '0;
               w_d     = '0;
               j_d     = arr_in[0];
               busy_d  = 1'b1;
               state_d = ACC;
            end
         end

         ACC: begin
            sum_d = sum_q + SW'(bus.Cost);
            if (w_q == LAST) begin
               w_d     = '0;
               j_d     = '0;
               state_d = CMP;
            end else begin
               w_d = w_inc;
               j_d = arr_q[w_inc];
            end
         end

         CMP: begin
            if (sum_q < min_q) begin
               min_d  = sum_q;
               cnt_d  = MCW'(1);
               best_d = perm_q;
            end else if (sum_q == min_q) begin
               if (cnt_q != '1) begin
                  cnt_d = cnt_q + MCW'(1);
               end
            end
            perm_d  = perm_q + PW'(1);
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin : regs
      if (RST) begin
         state_q <= IDLE;
         arr_q   <= '{default: '0};
         w_q     <= '0;
         j_q     <= '0;
         sum_q   <= '0;
         min_q   <= '1;
         cnt_q   <= '0;
         perm_q  <= '0;
         best_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         arr_q   <= arr_d;
         w_q     <= w_d;
         j_q     <= j_d;
         sum_q   <= sum_d;
         min_q   <= min_d;
         cnt_q   <= cnt_d;
         perm_q  <= perm_d;
         best_q  <= best_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.W          = w_q;
   assign bus.J          = j_q;
   assign bus.MinCost    = min_q;
   assign bus.MatchCount = cnt_q;
   assign bus.BestIdx    = best_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_jam_cost_tracker.sv
// Scoreboard bench: two trackers (full-width and 2-bit MatchCount) run in
// lockstep against a plain-arithmetic model of the minimum-cost rules.
module tb_jam_cost_tracker;

   localparam int unsigned N     = 8;
   localparam int unsigned IW    = 3;
   localparam int unsigned CW    = 7;
   localparam int unsigned SW    = 10;
   localparam int unsigned MCW   = 16;
   localparam int unsigned MCW_S = 2;
   localparam int unsigned PW    = 16;

   typedef struct {
      int min_cost;
      int cnt;
      int cnt_s;
      int best;
   } exp_t;

   logic CLK;
   logic RST;
   logic [CW-1:0] cost_tab [N][N];

   exp_t sb[$];
   int   total;
   int   bad;

   int m_min, m_cnt, m_cnt_s, m_perm, m_best;

   jam_cost_if #(.N(N), .IW(IW), .CW(CW), .SW(SW), .MCW(MCW),   .PW(PW)) bm ();
   jam_cost_if #(.N(N), .IW(IW), .CW(CW), .SW(SW), .MCW(MCW_S), .PW(PW)) bs ();

   jam_cost_tracker #(.N(N), .IW(IW), .CW(CW), .SW(SW), .MCW(MCW), .PW(PW)) dut_m (
      .CLK (CLK),
      .RST (RST),
      .bus (bm.slave)
   );

   jam_cost_tracker #(.N(N), .IW(IW), .CW(CW), .SW(SW), .MCW(MCW_S), .PW(PW)) dut_s (
      .CLK (CLK),
      .RST (RST),
      .bus (bs.slave)
   );

   assign bm.Cost    = cost_tab[bm.W][bm.J];
   assign bs.Cost    = cost_tab[bs.W][bs.J];
   assign bs.start   = bm.start;
   assign bs.clear   = bm.clear;
   assign bs.arrange = bm.arrange;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_min   = (1 << SW) - 1;
      m_cnt   = 0;
      m_cnt_s = 0;
      m_perm  = 0;
      m_best  = 0;
   endfunction

   function automatic logic [N*IW-1:0] mk_ident(input bit rev);
      logic [N*IW-1:0] a;
      for (int k = 0; k < N; k++) begin
         a[k*IW +: IW] = rev ? IW'(N - 1 - k) : IW'(k);
      end
      return a;
   endfunction

   function automatic logic [N*IW-1:0] mk_random_perm();
      int p[N];
      int j, tmp;
      logic [N*IW-1:0] a;
      for (int k = 0; k < N; k++) p[k] = k;
      for (int k = N - 1; k > 0; k--) begin
         j    = int'($urandom_range(k, 0));
         tmp  = p[k];
         p[k] = p[j];
         p[j] = tmp;
      end
      for (int k = 0; k < N; k++) a[k*IW +: IW] = IW'(p[k]);
      return a;
   endfunction

   // Diagonal entries chosen so an identity assignment totals t.
   task automatic set_diag(input int t);
      int base;
      base = t / N;
      for (int k = 0; k < N; k++) begin
         cost_tab[k][k] = CW'((k == N - 1) ? (t - (N - 1) * base) : base);
      end
   endtask

   task automatic fill_table(input int maxv);
      for (int w = 0; w < N; w++)
         for (int j = 0; j < N; j++)
            cost_tab[w][j] = CW'($urandom_range(maxv, 0));
   endtask

   // Issue one evaluation from a negedge; returns on the done negedge.
   task automatic run_eval(input logic [N*IW-1:0] arr, input bit clr, input bit poke);
      int t;
      exp_t e;
      t = 0;
      for (int k = 0; k < N; k++) t += int'(cost_tab[k][arr[k*IW +: IW]]);
      if (clr) model_reset();
      if (t < m_min) begin
         m_min   = t;
         m_cnt   = 1;
         m_cnt_s = 1;
         m_best  = m_perm;
      end else if (t == m_min) begin
         if (m_cnt < (1 << MCW) - 1)     m_cnt++;
         if (m_cnt_s < (1 << MCW_S) - 1) m_cnt_s++;
      end
      m_perm     = (m_perm + 1) % (1 << PW);
      e.min_cost = m_min;
      e.cnt      = m_cnt;
      e.cnt_s    = m_cnt_s;
      e.best     = m_best;
      sb.push_back(e);

      bm.start   = 1'b1;
      bm.clear   = clr;
      bm.arrange = arr;
      for (int k = 0; k < N; k++) begin
         @(negedge CLK);
         if (k == 0) begin
            bm.start = 1'b0;
            bm.clear = 1'b0;
         end
         if (poke && k == 3) bm.start = 1'b1;
         if (poke && k == 4) bm.start = 1'b0;
         chk("acc_W", int'(bm.W), k);
         chk("acc_J", int'(bm.J), int'(arr[k*IW +: IW]));
         chk("acc_busy", int'(bm.busy), 1);
      end
      @(negedge CLK);
      chk("cmp_W", int'(bm.W), 0);
      chk("cmp_J", int'(bm.J), 0);
      chk("cmp_busy", int'(bm.busy), 1);
      chk("cmp_done", int'(bm.done), 0);
      @(negedge CLK);
      chk("done_latency", int'(bm.done), 1);
      chk("done_busy", int'(bm.busy), 0);
   endtask

   // Monitor: every done pulse retires one scoreboard entry.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge CLK);
         if (!RST && bm.done) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
            end else begin
               e = sb.pop_front();
               chk("MinCost", int'(bm.MinCost), e.min_cost);
               chk("MatchCount", int'(bm.MatchCount), e.cnt);
               chk("BestIdx", int'(bm.BestIdx), e.best);
               chk("sat_done", int'(bs.done), 1);
               chk("sat_MatchCount", int'(bs.MatchCount), e.cnt_s);
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   task automatic chk_reset_values(input string tag);
      chk({tag, "_MinCost"}, int'(bm.MinCost), (1 << SW) - 1);
      chk({tag, "_MatchCount"}, int'(bm.MatchCount), 0);
      chk({tag, "_BestIdx"}, int'(bm.BestIdx), 0);
      chk({tag, "_W"}, int'(bm.W), 0);
      chk({tag, "_J"}, int'(bm.J), 0);
      chk({tag, "_busy"}, int'(bm.busy), 0);
      chk({tag, "_done"}, int'(bm.done), 0);
      chk({tag, "_sat_MatchCount"}, int'(bs.MatchCount), 0);
   endtask

   initial begin : driver
      int totals[8] = '{50, 45, 40, 35, 30, 50, 30, 30};
      int dones;
      logic [N*IW-1:0] arr;
      total = 0;
      bad   = 0;
      RST        = 1'b1;
      bm.start   = 1'b0;
      bm.clear   = 1'b0;
      bm.arrange = '0;
      for (int w = 0; w < N; w++)
         for (int j = 0; j < N; j++)
            cost_tab[w][j] = CW'(5);
      model_reset();
      repeat (2) @(negedge CLK);
      chk_reset_values("reset");
      RST = 1'b0;
      @(negedge CLK);

      // Uniform table: total 40.
      run_eval(mk_ident(1'b0), 1'b0, 1'b0);

      // Decreasing then tied totals after a clear.
      for (int i = 0; i < 8; i++) begin
         set_diag(totals[i]);
         run_eval(mk_ident(1'b0), i == 0, 1'b0);
      end

      // Anti-diagonal lookup, with a stray start during ACC.
      fill_table(127);
      run_eval(mk_ident(1'b1), 1'b0, 1'b1);

      // Clear and start together, then a run totalling 60.
      set_diag(60);
      run_eval(mk_ident(1'b0), 1'b1, 1'b0);

      // Four equal totals saturate the 2-bit counter.
      set_diag(20);
      for (int i = 0; i < 4; i++) run_eval(mk_ident(1'b0), i == 0, 1'b0);

      // Random permutations over small costs to provoke ties.
      for (int i = 0; i < 30; i++) begin
         if (i % 5 == 0) fill_table(3);
         run_eval(mk_random_perm(), ($urandom_range(7, 0) == 0), 1'b0);
      end

      // Reset during the 4th ACC cycle: no done may follow.
      arr        = mk_random_perm();
      bm.start   = 1'b1;
      bm.arrange = arr;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         bm.start = 1'b0;
      end
      RST = 1'b1;
      #1;
      chk_reset_values("midrst");
      @(negedge CLK);
      RST = 1'b0;
      model_reset();
      dones = 0;
      for (int c = 0; c < N + 4; c++) begin
         @(negedge CLK);
         if (bm.done || bs.done) dones++;
      end
      chk("no_done_after_rst", dones, 0);

      fill_table(127);
      run_eval(mk_random_perm(), 1'b0, 1'b0);

      repeat (3) @(negedge CLK);
      chk("scoreboard_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jam_cost_tracker.md
# jam_cost_tracker

Parametrised cost evaluator for the job-assignment machine. For each candidate permutation it walks all N workers, fetches each worker/job cost over the W/J cost-lookup port, sums the costs, and keeps a running minimum total, the number of permutations that hit that minimum, and the index of the first permutation that achieved it. It sits between the permutation generator, which supplies `arrange` and `start`, and the combinational cost table, which drives `Cost` from `W`/`J`.

## Interface
- N, 8, number of workers and jobs (≥2)
- IW, $clog2(N), worker/job index width
- CW, 7, width of one cost entry
- SW, 10, width of accumulated total; must satisfy SW ≥ CW + $clog2(N)
- MCW, 16, MatchCount width (saturating)
- PW, 16, permutation index width (wrapping)
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  asynchronous, active-high reset
- start  in  1  begin evaluating `arrange`; sampled only in IDLE
- clear  in  1  restart tracking for a new job set; sampled only in IDLE
- arrange  in  N*IW  packed permutation; slice k = job assigned to worker k; latched on accepted start
- W  out  IW  worker index for cost lookup
- J  out  IW  job index for cost lookup
- Cost  in  CW  cost of (W,J); combinational response in the same cycle
- MinCost  out  SW  lowest total seen since reset or clear
- MatchCount  out  MCW  number of permutations whose total equals MinCost
- BestIdx  out  PW  index of the first permutation that reached the current MinCost
- busy  out  1  high in ACC and CMP
- done  out  1  one-cycle pulse when the outputs reflect the latest evaluation

## Operation
- States: IDLE, ACC, CMP.
- IDLE:
  - clear=1: MinCost←all ones, MatchCount←0, permutation counter←0, BestIdx←0.
  - start=1: latch `arrange`, sum←0, k←0, go to ACC.
  - clear and start together: both take effect. The new evaluation compares against the cleared state.
- ACC:
  - W=k, J=arrange_latched[k].
  - Each cycle: sum←sum+Cost (zero-extended to SW), k←k+1.
  - When k=N−1 the last cost is added and the state goes to CMP.
- CMP, compare total T against MinCost:
  - T<MinCost: MinCost←T, MatchCount←1, BestIdx←permutation counter.
  - T=MinCost: MatchCount←MatchCount+1, saturating at all ones. BestIdx is unchanged.
  - T>MinCost: no change.
  - In all cases the permutation counter increments (wraps at 2^PW). Next state is IDLE with done=1.
- start or clear outside IDLE is ignored and not queued.
- Outside ACC, W and J hold 0.
- Arithmetic is unsigned. Sum overflow is impossible by the SW parameter rule; this is not checked in RTL.

## Timing
- Reset values: MinCost all ones, MatchCount 0, BestIdx 0, W 0, J 0, busy 0, done 0, state IDLE, counters 0.
- start accepted at edge E0:
  - busy is high from E0 to E(N+1).
  - ACC covers edges E1..EN, with W=0..N−1 in the cycles before those edges.
  - The compare registers at E(N+1).
  - done is high for exactly one cycle after E(N+1), with updated MinCost, MatchCount and BestIdx visible in that same cycle.
- Latency from start to done is N+1 cycles. Throughput is one evaluation per N+2 cycles (start may be asserted during the done cycle, which is IDLE).
- RST mid-operation: immediate return to reset values, the partial sum is discarded, and no done pulse follows.
- Outputs change only on the CMP edge, on a clear in IDLE, or on reset.

## Test plan
- Reset, then one evaluation with N=8 and a table returning 5 for every (W,J). Required: W steps 0..7, done 9 cycles after start, MinCost=40, MatchCount=1, BestIdx=0.
- Eight evaluations with totals 50,45,40,35,30,50,30,30. Required after each done:
  - MinCost: 50,45,40,35,30,30,30,30
  - MatchCount: 1,1,1,1,1,1,2,3
  - BestIdx stays 4 from the fifth evaluation on.
- Permutation mapping: set arrange to reverse order (worker k→job 7−k). Required: J follows 7,6,…,0 in lockstep with W 0..7; the sum matches the table entries on the anti-diagonal.
- Clear and start asserted in the same IDLE cycle after the MinCost=30 run, then a run totalling 60. Required: MinCost=60, MatchCount=1, BestIdx=0.
- Saturation with MCW=2: four equal totals. Required: MatchCount reads 1,2,3,3.
- RST pulsed at the 4th ACC cycle. Required: all outputs return to reset values immediately and no done pulse follows. A start pulse during ACC is ignored, giving exactly one done.
